// File: rtl/hot_tracker_ctrl_pkg.sv
// hot_tracker_ctrl_pkg: shared epoch-controller state type and default constants
package hot_tracker_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, QUERY, DRAIN} t_epoch_state;
  localparam int DRAIN_IDLE_DEF = 64;
  localparam int STAT_W_DEF = 16;
endpackage

// File: rtl/mig_out_reg.sv
// mig_out_reg: one-entry valid/ready pipeline register with pass-through accept
module mig_out_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  assign in_ready = !out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/hot_tracker_epoch_ctrl.sv
// hot_tracker_epoch_ctrl: epoch sequencer issuing tracker queries and draining budgeted migration addresses
module hot_tracker_epoch_ctrl
  import hot_tracker_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 33,
  parameter int EPOCH_W    = 32,
  parameter int BUDGET_W   = 8,
  parameter int DRAIN_IDLE = DRAIN_IDLE_DEF,
  parameter int STAT_W     = STAT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 csr_enable,
  input  logic [EPOCH_W-1:0]   csr_epoch_len,
  input  logic [BUDGET_W-1:0]  csr_mig_budget,
  output logic                 query_en,
  input  logic                 query_ready,
  input  logic                 ht_mig_addr_en,
  input  logic [ADDR_SIZE-1:0] ht_mig_addr,
  output logic                 ht_mig_addr_ready,
  output logic                 out_mig_valid,
  output logic [ADDR_SIZE-1:0] out_mig_addr,
  input  logic                 out_mig_ready,
  output logic                 epoch_done,
  output logic [STAT_W-1:0]    stat_mig_cnt,
  output logic [STAT_W-1:0]    stat_drop_cnt,
  output logic                 busy
);
  localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_IDLE - 1);
  t_epoch_state state, state_nxt;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [BUDGET_W-1:0] budget_left;
  logic [IDLE_W-1:0] idle_cnt;
  logic in_drain, has_budget, reg_in_ready, accept, fwd, hs, drain_end;
  assign in_drain = state == DRAIN;
  assign has_budget = budget_left != '0;
  assign ht_mig_addr_ready = in_drain & (!has_budget | reg_in_ready);
  assign accept = ht_mig_addr_en & ht_mig_addr_ready;
  assign fwd = accept & has_budget;
  assign hs = query_en & query_ready;
  assign drain_end = in_drain & (idle_cnt == IDLE_MAX) & !out_mig_valid;
  assign epoch_done = drain_end;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (csr_enable ? COUNT : IDLE) :
                state == COUNT ? (!csr_enable ? IDLE : epoch_cnt == '0 ? QUERY : COUNT) :
                state == QUERY ? (hs ? DRAIN : QUERY) :
                drain_end      ? (csr_enable ? COUNT : IDLE) : DRAIN;
  end
  // idle_cnt saturates so a long output stall cannot skip the drain exit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      query_en <= 1'b0;
      epoch_cnt <= '0;
      budget_left <= '0;
      idle_cnt <= '0;
      stat_mig_cnt <= '0;
      stat_drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      query_en <= (state == QUERY) & !hs;
      epoch_cnt <= (state_nxt == COUNT && state != COUNT)
                 ? (csr_epoch_len == '0 ? '0 : csr_epoch_len - 1'b1)
                 : epoch_cnt - EPOCH_W'(state == COUNT);
      budget_left <= hs ? csr_mig_budget : budget_left - BUDGET_W'(fwd);
      idle_cnt <= (hs | ht_mig_addr_en) ? '0
                : idle_cnt + IDLE_W'(in_drain & (idle_cnt != IDLE_MAX));
      stat_mig_cnt <= stat_mig_cnt + STAT_W'(fwd & ~&stat_mig_cnt);
      stat_drop_cnt <= stat_drop_cnt + STAT_W'(accept & !has_budget & ~&stat_drop_cnt);
    end
  end
  mig_out_reg #(.W(ADDR_SIZE)) u_out (
    .clk(clk),
    .rstn(rstn),
    .in_valid(fwd),
    .in_data(ht_mig_addr),
    .in_ready(reg_in_ready),
    .out_valid(out_mig_valid),
    .out_data(out_mig_addr),
    .out_ready(out_mig_ready)
  );
endmodule

// File: tb/tb_hot_tracker_epoch_ctrl.sv
// tb_hot_tracker_epoch_ctrl: directed and randomized checks against a behavioural epoch model
module tb_hot_tracker_epoch_ctrl;
  localparam int AW = 33, EW = 32, BW = 8, DI = 64, SW = 16;
  logic clk = 0, rstn = 0, csr_enable = 0;
  logic [EW-1:0] csr_epoch_len = '0;
  logic [BW-1:0] csr_mig_budget = '0;
  logic query_en, query_ready = 0, ht_mig_addr_en = 0;
  logic [AW-1:0] ht_mig_addr = '0;
  logic ht_mig_addr_ready, out_mig_valid, out_mig_ready = 0, epoch_done, busy;
  logic [AW-1:0] out_mig_addr;
  logic [SW-1:0] stat_mig_cnt, stat_drop_cnt;
  hot_tracker_epoch_ctrl dut (
    .clk(clk), .rstn(rstn), .csr_enable(csr_enable), .csr_epoch_len(csr_epoch_len),
    .csr_mig_budget(csr_mig_budget), .query_en(query_en), .query_ready(query_ready),
    .ht_mig_addr_en(ht_mig_addr_en), .ht_mig_addr(ht_mig_addr),
    .ht_mig_addr_ready(ht_mig_addr_ready), .out_mig_valid(out_mig_valid),
    .out_mig_addr(out_mig_addr), .out_mig_ready(out_mig_ready), .epoch_done(epoch_done),
    .stat_mig_cnt(stat_mig_cnt), .stat_drop_cnt(stat_drop_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // model: phase 0 idle, 1 counting, 2 querying, 3 draining
  int ph = 0, cnt = 0, bud = 0, idle = 0, mig = 0, drop = 0, cyc = 0;
  bit qen = 0, ov = 0;
  logic [AW-1:0] oa = '0;
  int trk_mode = 0, trk_left = 0;
  logic [AW-1:0] trk_addr = '0;
  int q_times[$], d_times[$];
  logic [AW-1:0] fwd_q[$];
  bit stall_seen = 0;
  function automatic logic [AW-1:0] rnd_addr();
    return {1'($urandom % 2), 32'($urandom)};
  endfunction
  task automatic tick();
    bit hr, dn, acc, hs, fire;
    int nph, ld, b0;
    #1;
    hr = ph == 3 && (bud == 0 || !ov || out_mig_ready);
    dn = ph == 3 && idle == DI - 1 && !ov;
    check("query_en", query_en, qen);
    check("ht_ready", ht_mig_addr_ready, hr);
    check("out_valid", out_mig_valid, ov);
    check("out_addr", out_mig_addr, oa);
    check("epoch_done", epoch_done, dn);
    check("busy", busy, ph != 0);
    check("stat_mig", stat_mig_cnt, mig);
    check("stat_drop", stat_drop_cnt, drop);
    if (query_en) q_times.push_back(cyc);
    if (epoch_done) d_times.push_back(cyc);
    if (out_mig_valid && out_mig_ready) fwd_q.push_back(out_mig_addr);
    if (busy && ht_mig_addr_en && !ht_mig_addr_ready) stall_seen = 1;
    acc = ht_mig_addr_en && hr;
    hs = ph == 2 && qen && query_ready;
    fire = ov && out_mig_ready;
    ld = csr_epoch_len == 0 ? 0 : int'(csr_epoch_len) - 1;
    b0 = bud;
    if (!rstn) begin
      ph = 0; cnt = 0; bud = 0; idle = 0; mig = 0; drop = 0; qen = 0; ov = 0; oa = '0; trk_left = 0;
    end else begin
      if (acc && b0 > 0) begin
        ov = 1; oa = ht_mig_addr; bud--;
        if (mig < 65535) mig++;
      end else if (fire) ov = 0;
      if (acc && b0 == 0 && drop < 65535) drop++;
      if (acc) begin
        trk_left--;
        trk_addr = trk_mode == 1 ? trk_addr + 1 : rnd_addr();
      end
      nph = ph;
      if (ph == 0) begin
        if (csr_enable) begin nph = 1; cnt = ld; end
      end else if (ph == 1) begin
        if (!csr_enable) nph = 0;
        else if (cnt == 0) nph = 2;
        else cnt--;
      end else if (ph == 2) begin
        if (hs) begin
          nph = 3; bud = int'(csr_mig_budget); idle = 0;
          trk_left = trk_mode == 0 ? 0 : trk_mode == 1 ? 5 : $urandom_range(0, 7);
        end
      end else begin
        idle = ht_mig_addr_en ? 0 : (idle < DI - 1 ? idle + 1 : idle);
        if (dn) begin
          nph = csr_enable ? 1 : 0;
          cnt = ld;
        end
      end
      qen = ph == 2 && !hs;
      ph = nph;
    end
    cyc++;
  endtask
  task automatic cycle();
    ht_mig_addr_en = trk_left > 0 && (trk_mode == 1 || $urandom % 3 != 0);
    ht_mig_addr = trk_addr;
    tick();
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_qen"}, query_en, 0);
    check({tag, "_hready"}, ht_mig_addr_ready, 0);
    check({tag, "_ovalid"}, out_mig_valid, 0);
    check({tag, "_oaddr"}, out_mig_addr, 0);
    check({tag, "_done"}, epoch_done, 0);
    check({tag, "_mig"}, stat_mig_cnt, 0);
    check({tag, "_drop"}, stat_drop_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    int t0, nq, q0, q1, d0;
    @(negedge clk);
    rstn = 0;
    repeat (3) cycle();
    check_reset_outputs("reset");
    rstn = 1; csr_epoch_len = 10; csr_mig_budget = 4; query_ready = 1; out_mig_ready = 1;
    trk_mode = 0; csr_enable = 1; t0 = cyc; q_times.delete(); d_times.delete();
    repeat (100) cycle();
    q0 = q_times.size() > 0 ? q_times[0] : -1000;
    q1 = q_times.size() > 1 ? q_times[1] : -1000;
    d0 = d_times.size() > 0 ? d_times[0] : -1000;
    check("epoch_query_cnt", q_times.size(), 2);
    check("epoch_query_delay", q0 - t0, 12);
    check("epoch_done_delay", d0 - q0, 64);
    check("epoch_requery_delay", q1 - d0, 12);
    csr_enable = 0; d_times.delete(); nq = q_times.size();
    for (int i = 0; i < 200 && busy; i++) cycle();
    check("dis_drain_idle", busy, 0);
    check("dis_drain_done", d_times.size(), 1);
    check("dis_drain_noquery", q_times.size(), nq);
    csr_enable = 1;
    repeat (5) cycle();
    csr_enable = 0;
    cycle();
    check("dis_count_idle", busy, 0);
    repeat (20) cycle();
    check("dis_count_noquery", q_times.size(), nq);
    csr_epoch_len = 5; csr_mig_budget = 3; trk_mode = 1; trk_addr = 33'h10;
    fwd_q.delete(); d_times.delete(); stall_seen = 0; csr_enable = 1;
    for (int i = 0; i < 300 && d_times.size() == 0; i++) cycle();
    trk_mode = 0; csr_enable = 0;
    for (int i = 0; i < 200 && busy; i++) cycle();
    check("bud_done", d_times.size(), 1);
    check("bud_fwd_cnt", fwd_q.size(), 3);
    for (int i = 0; i < 3; i++) check("bud_fwd_addr", fwd_q.size() > i ? fwd_q[i] : '1, 33'h10 + 33'(i));
    check("bud_mig", stat_mig_cnt, 3);
    check("bud_drop", stat_drop_cnt, 2);
    check("bud_no_stall", stall_seen, 0);
    csr_epoch_len = 2; query_ready = 0; q_times.delete(); csr_enable = 1;
    repeat (30) cycle();
    check("qstall_held", q_times.size() >= 20, 1);
    check("qstall_busy", busy, 1);
    query_ready = 1; trk_mode = 2;
    for (int i = 0; i < 5000; i++) begin
      if (i % 50 == 0) begin
        csr_epoch_len = EW'($urandom_range(0, 6));
        csr_mig_budget = BW'($urandom_range(0, 4));
      end
      out_mig_ready = $urandom % 4 != 0;
      query_ready = $urandom % 3 != 0;
      csr_enable = $urandom % 40 != 0;
      rstn = $urandom % 700 != 0;
      cycle();
    end
    rstn = 1; csr_enable = 1; csr_epoch_len = 2; csr_mig_budget = 4; query_ready = 1; out_mig_ready = 0;
    for (int i = 0; i < 800 && !out_mig_valid; i++) cycle();
    check("rst_drain_valid", out_mig_valid, 1);
    rstn = 0;
    cycle();
    check_reset_outputs("rst_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
